// File: rtl/sound_ram_arbiter_if.sv
// Sound RAM arbiter bus bundle: DOC fetch port, GLU host port and sound RAM port.
// slave  : the arbiter itself
// master : the surroundings (DOC, GLU host and the RAM)
interface sound_ram_arbiter_if;
    logic        doc_req;
    logic [15:0] doc_addr;
    logic [7:0]  doc_data;
    logic        doc_valid;

    logic        host_req;
    logic        host_wr;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        busy;

    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport slave (
        input  doc_req, doc_addr, host_req, host_wr, host_addr, host_wdata, ram_rdata,
        output doc_data, doc_valid, host_ack, host_rdata, busy, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output doc_req, doc_addr, host_req, host_wr, host_addr, host_wdata, ram_rdata,
        input  doc_data, doc_valid, host_ack, host_rdata, busy, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/sound_ram_arbiter.sv
// Sound RAM arbiter: shares one registered sound RAM between the DOC sample
// fetcher (absolute priority, never stalled) and GLU host accesses.
// Optional feature: define SNDRAM_WRBUF_EN for a one-entry posted host write
// buffer (write acked the cycle after host_req, committed at first non-DOC cycle).
module sound_ram_arbiter (
    input logic               CLK_14M,
    input logic               reset,
    sound_ram_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;

    logic [1:0]  state;
    logic        pend_wr;
    logic [15:0] pend_addr;
    logic [7:0]  pend_wdata;
    logic        doc_valid_q;
    logic [7:0]  rdata_q;
    logic        wr_ack_q;
    logic        busy_int;
    logic        accept;
    logic        host_grant;

`ifdef SNDRAM_WRBUF_EN
    logic        buf_full;
    logic [15:0] buf_addr;
    logic [7:0]  buf_wdata;
    logic        buf_grant;

    assign busy_int   = (state != ST_IDLE) || buf_full;
    assign buf_grant  = !bus.doc_req && buf_full;
    assign host_grant = !bus.doc_req && !buf_full && (state == ST_PEND);
`else
    assign busy_int   = (state != ST_IDLE);
    assign host_grant = !bus.doc_req && (state == ST_PEND);
`endif

    assign accept = bus.host_req && !busy_int;

    // RAM port mux: DOC first, then buffered write, then pending host access
    always_comb begin
        bus.ram_addr  = bus.doc_addr;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = pend_wdata;
`ifdef SNDRAM_WRBUF_EN
        if (buf_grant) begin
            bus.ram_addr  = buf_addr;
            bus.ram_we    = !reset;
            bus.ram_wdata = buf_wdata;
        end else
`endif
        if (host_grant) begin
            bus.ram_addr  = pend_addr;
            bus.ram_we    = pend_wr && !reset;
            bus.ram_wdata = pend_wdata;
        end
    end

    // Host access FSM: IDLE -> PEND (wait for a free slot) -> RDATA (reads only)
    always_ff @(posedge CLK_14M) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef SNDRAM_WRBUF_EN
                    if (accept && !bus.host_wr) state <= ST_PEND;
`else
                    if (accept) state <= ST_PEND;
`endif
                end
                ST_PEND: begin
                    if (host_grant) state <= pend_wr ? ST_IDLE : ST_RDATA;
                end
                ST_RDATA: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Latch the host request fields when a request is accepted
    always_ff @(posedge CLK_14M) begin
        if (reset) begin
            pend_wr    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
        end else if (accept) begin
            pend_wr    <= bus.host_wr;
            pend_addr  <= bus.host_addr;
            pend_wdata <= bus.host_wdata;
        end
    end

`ifdef SNDRAM_WRBUF_EN
    // Posted write buffer: filled on an accepted write, drained at the first non-DOC cycle
    always_ff @(posedge CLK_14M) begin
        if (reset) begin
            buf_full  <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else if (buf_grant) begin
            buf_full  <= 1'b0;
        end else if (accept && bus.host_wr) begin
            buf_full  <= 1'b1;
            buf_addr  <= bus.host_addr;
            buf_wdata <= bus.host_wdata;
        end
    end

    // Posted writes are acknowledged the cycle after host_req
    always_ff @(posedge CLK_14M) begin
        if (reset) wr_ack_q <= 1'b0;
        else       wr_ack_q <= accept && bus.host_wr;
    end
`else
    // Direct writes are acknowledged the cycle after the RAM write
    always_ff @(posedge CLK_14M) begin
        if (reset) wr_ack_q <= 1'b0;
        else       wr_ack_q <= host_grant && pend_wr;
    end
`endif

    // Hold the last completed read byte between read completions
    always_ff @(posedge CLK_14M) begin
        if (reset)                  rdata_q <= '0;
        else if (state == ST_RDATA) rdata_q <= bus.ram_rdata;
    end

    // DOC data arrives one cycle after its request (registered RAM)
    always_ff @(posedge CLK_14M) begin
        if (reset) doc_valid_q <= 1'b0;
        else       doc_valid_q <= bus.doc_req;
    end

    // Read completion is visible in the RDATA cycle itself, so data bypasses the holding register
    assign bus.host_rdata = (state == ST_RDATA && !reset) ? bus.ram_rdata : rdata_q;
    assign bus.host_ack   = !reset && ((state == ST_RDATA) || wr_ack_q);
    assign bus.busy       = busy_int;
    assign bus.doc_valid  = doc_valid_q;
    assign bus.doc_data   = doc_valid_q ? bus.ram_rdata : '0;

endmodule

// File: doc/sound_ram_arbiter.md
SOUND_RAM_ARBITER -- requirements
Module: sound_ram_arbiter

Interface
REQ-001 SHALL have port: CLK_14M  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: doc_req  input  1  DOC sample-fetch request for the current cycle (level).
REQ-004 SHALL have port: doc_addr  input  16  DOC sample address.
REQ-005 SHALL have port: doc_data  output  8  fetched sample byte.
REQ-006 SHALL have port: doc_valid  output  1  doc_data valid this cycle.
REQ-007 SHALL have port: host_req  input  1  single-cycle GLU access request pulse.
REQ-008 SHALL have port: host_wr  input  1  request is a write (sampled with host_req).
REQ-009 SHALL have port: host_addr  input  16  GLU RAM address (sampled with host_req).
REQ-010 SHALL have port: host_wdata  input  8  write data (sampled with host_req).
REQ-011 SHALL have port: host_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: host_rdata  output  8  read data, valid when host_ack pulses for a read.
REQ-013 SHALL have port: busy  output  1  host request pending; new host_req ignored while high.
REQ-014 SHALL have port: ram_addr  output  16  sound RAM address, combinational from the granted source.
REQ-015 SHALL have port: ram_we  output  1  sound RAM write enable.
REQ-016 SHALL have port: ram_wdata  output  8  sound RAM write data.
REQ-017 SHALL have port: ram_rdata  input  8  sound RAM read data, one cycle after the address (registered RAM).

Function
REQ-018 Per cycle, grant SHALL be: DOC if doc_req; else buffered write (if any); else pending host access; else none (ram_addr=doc_addr, ram_we=0).
REQ-019 DOC SHALL never be stalled; doc_valid SHALL assert exactly one cycle after every doc_req cycle, with doc_data=ram_rdata.
REQ-020 Host FSM states SHALL be IDLE, PEND, RDATA.
REQ-021 IDLE: host_req with busy low latches host_wr/addr/wdata and goes to PEND; host_req while busy high SHALL be dropped silently.
REQ-022 PEND: when granted, reads SHALL go to RDATA; writes SHALL drive ram_we=1 for that one cycle and return to IDLE with host_ack pulsing the next cycle.
REQ-023 RDATA: host_rdata SHALL capture ram_rdata and host_ack SHALL pulse in that cycle; next state IDLE.
REQ-024 Unloaded read latency SHALL be host_req at cycle 0, ram_addr=host_addr at cycle 1, host_ack with data at cycle 2.
REQ-025 busy SHALL be high in PEND and RDATA, and while the write buffer is full.
REQ-026 host_rdata SHALL hold its value until the next read completion.
REQ-027 Host access SHALL wait indefinitely while doc_req stays high; no timeout.

Reset
REQ-028 On reset: state IDLE, write buffer empty, busy=0, host_ack=0, doc_valid=0, host_rdata=0, doc_data=0, ram_we=0.
REQ-029 Reset mid-operation SHALL discard pending and buffered accesses without any RAM write or host_ack.

Configuration
REQ-030 Macro SNDRAM_WRBUF_EN defined: host writes accepted in IDLE SHALL go to a one-entry posted buffer, host_ack SHALL pulse the cycle after host_req, and the buffer SHALL commit at the first non-DOC cycle.
REQ-031 A read accepted while the buffer is full SHALL be blocked by busy; with the buffer empty, a read SHALL run normally.
REQ-032 Macro undefined: no buffer exists, and writes SHALL complete per REQ-022 only.

Verification
REQ-033 Idle read: mem[0x1234]=0xA5, host_req rd 0x1234 at cycle 0, doc_req=0 -> host_ack and host_rdata=0xA5 at cycle 2.
REQ-034 DOC priority: doc_req high cycles 1-4 with addr 0x0100..0x0103, host read at cycle 0 -> doc_valid cycles 2-5 with correct bytes; host_ack at cycle 6.
REQ-035 Write: host write 0x3C to 0x8000 with doc idle -> ram_we one cycle at addr 0x8000; a later read returns 0x3C; with SNDRAM_WRBUF_EN, host_ack at cycle 1.
REQ-036 Busy drop: second host_req one cycle after the first -> ignored; exactly one host_ack.
REQ-037 Reset mid-PEND with doc_req held high -> no ram_we, no host_ack; busy=0 the cycle after reset.
